// File: rtl/line_timing_decoder_if.sv
// Line timing decoder bus: raw blank/sync in, recovered position and published timing out.
interface line_timing_decoder_if;
   logic       blank_in;
   logic       sync_in;
   logic [9:0] x_pos;
   logic       active;
   logic       locked;
   logic [9:0] line_len;
   logic [9:0] act_w;
   logic [9:0] sync_start;
   logic [9:0] sync_end;
   logic       timing_err;

   modport master (
      output blank_in, sync_in,
      input  x_pos, active, locked, line_len, act_w, sync_start, sync_end, timing_err
   );

   modport slave (
      input  blank_in, sync_in,
      output x_pos, active, locked, line_len, act_w, sync_start, sync_end, timing_err
   );
endinterface

// File: rtl/line_timing_decoder.sv
// Recovers horizontal line timing from blank/sync, locks after LOCK_LINES identical lines.
//
// state   | meaning
// SEARCH  | waiting for the first blank fall
// MEASURE | measuring one line to become the reference
// TRACK   | counting lines identical to the reference
// LOCKED  | timing published; any mismatch or timeout drops lock
module line_timing_decoder #(
   parameter int LOCK_LINES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   line_timing_decoder_if.slave tim
);

   typedef enum logic [1:0] {SEARCH, MEASURE, TRACK, LOCKED} state_t;

   localparam logic [3:0] LOCK_LAST = 4'(LOCK_LINES - 1);

   state_t     state, state_nxt;
   logic       blank_q, sync_q;
   logic [9:0] x_pos;
   logic [1:0] n_br, n_sr, n_sf;
   logic [9:0] w_act, w_ss, w_se;
   logic [9:0] r_len, r_act, r_ss, r_se;
   logic [9:0] p_len, p_act, p_ss, p_se;
   logic [3:0] match_cnt;
   logic       timing_err_q;

   logic       blank_fall, blank_rise, sync_rise, sync_fall;
   logic [9:0] cur_len;
   logic       line_ok, line_eq, timeout;
   logic       load_ref, clr_cnt, inc_cnt, publish, err_nxt;

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

   assign blank_fall = blank_q & ~tim.blank_in;
   assign blank_rise = ~blank_q & tim.blank_in;
   assign sync_rise  = ~sync_q & tim.sync_in;
   assign sync_fall  = sync_q & ~tim.sync_in;
   // A blank fall at x_pos 1023 wraps cur_len to 0, which fails the ordering test below.
   assign cur_len    = x_pos + 10'd1;
   assign timeout    = (x_pos == 10'd1023) && !blank_fall;

   assign line_ok = (n_br == 2'd1) && (n_sr == 2'd1) && (n_sf == 2'd1) &&
                    (w_act <= w_ss) && (w_ss < w_se) && (w_se <= cur_len);
   assign line_eq = line_ok && (cur_len == r_len) && (w_act == r_act) &&
                    (w_ss == r_ss) && (w_se == r_se);

   // Input registers and saturating pixel counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank_q <= 1'b1;
         sync_q  <= 1'b0;
         x_pos   <= '0;
      end else begin
         blank_q <= tim.blank_in;
         sync_q  <= tim.sync_in;
         if (blank_fall)
            x_pos <= '0;
         else if (x_pos != 10'd1023)
            x_pos <= x_pos + 10'd1;
      end
   end

   // Working set of the line in progress; sync edges on the blank fall belong to the new line at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_br  <= '0;
         n_sr  <= '0;
         n_sf  <= '0;
         w_act <= '0;
         w_ss  <= '0;
         w_se  <= '0;
      end else if (blank_fall) begin
         n_br  <= '0;
         n_sr  <= {1'b0, sync_rise};
         n_sf  <= {1'b0, sync_fall};
         w_act <= '0;
         w_ss  <= '0;
         w_se  <= '0;
      end else begin
         if (blank_rise) begin
            n_br  <= sat_inc(n_br);
            w_act <= cur_len;
         end
         if (sync_rise) begin
            n_sr <= sat_inc(n_sr);
            w_ss <= cur_len;
         end
         if (sync_fall) begin
            n_sf <= sat_inc(n_sf);
            w_se <= cur_len;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= SEARCH;
      else
         state <= state_nxt;
   end

   // Next-state and datapath control.
   always_comb begin
      state_nxt = state;
      load_ref  = 1'b0;
      clr_cnt   = 1'b0;
      inc_cnt   = 1'b0;
      publish   = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         SEARCH: begin
            clr_cnt = 1'b1;
            if (blank_fall)
               state_nxt = MEASURE;
         end
         MEASURE: begin
            if (timeout) begin
               state_nxt = SEARCH;
            end else if (blank_fall && line_ok) begin
               load_ref  = 1'b1;
               clr_cnt   = 1'b1;
               state_nxt = TRACK;
            end
         end
         TRACK: begin
            if (timeout) begin
               state_nxt = SEARCH;
            end else if (blank_fall) begin
               if (line_eq) begin
                  inc_cnt = 1'b1;
                  if (match_cnt + 4'd1 == LOCK_LAST) begin
                     publish   = 1'b1;
                     state_nxt = LOCKED;
                  end
               end else begin
                  load_ref = 1'b1;
                  clr_cnt  = 1'b1;
               end
            end
         end
         LOCKED: begin
            if (timeout) begin
               err_nxt   = 1'b1;
               state_nxt = SEARCH;
            end else if (blank_fall && !line_eq) begin
               err_nxt   = 1'b1;
               state_nxt = MEASURE;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   // Reference, match counter, published timing and error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len        <= '0;
         r_act        <= '0;
         r_ss         <= '0;
         r_se         <= '0;
         p_len        <= '0;
         p_act        <= '0;
         p_ss         <= '0;
         p_se         <= '0;
         match_cnt    <= '0;
         timing_err_q <= 1'b0;
      end else begin
         timing_err_q <= err_nxt;
         if (load_ref) begin
            r_len <= cur_len;
            r_act <= w_act;
            r_ss  <= w_ss;
            r_se  <= w_se;
         end
         if (publish) begin
            p_len <= r_len;
            p_act <= r_act;
            p_ss  <= r_ss;
            p_se  <= r_se;
         end
         if (clr_cnt)
            match_cnt <= '0;
         else if (inc_cnt)
            match_cnt <= match_cnt + 4'd1;
      end
   end

   assign tim.x_pos      = x_pos;
   assign tim.locked     = (state == LOCKED);
   assign tim.active     = (state == LOCKED) & ~blank_q;
   assign tim.line_len   = p_len;
   assign tim.act_w      = p_act;
   assign tim.sync_start = p_ss;
   assign tim.sync_end   = p_se;
   assign tim.timing_err = timing_err_q;

endmodule

// File: tb/tb_line_timing_decoder.sv
// Directed bench for line_timing_decoder using a 528-pixel reference line.
module tb_line_timing_decoder;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   err_hi = 0;
   int   a;
   logic l;
   logic lk_a, lk_b, eb;
   logic [9:0] xa;

   always #5 clk = ~clk;

   line_timing_decoder_if tim ();

   line_timing_decoder #(.LOCK_LINES(4)) dut (
      .clk (clk),
      .rst (rst),
      .tim (tim)
   );

   // Count cycles with timing_err high; each event must add exactly one.
   always @(negedge clk) begin
      if (tim.timing_err === 1'b1)
         err_hi++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive npix pixels; blank high from bstart, sync high over [ss, se).
   task automatic drive_line(input int npix, input int bstart, input int ss, input int se,
                             output int act_cnt, output logic lk0);
      act_cnt = 0;
      lk0     = 1'b0;
      for (int p = 0; p < npix; p++) begin
         tim.blank_in = (p >= bstart);
         tim.sync_in  = (p >= ss) && (p < se);
         @(posedge clk);
         #1;
         if (tim.active === 1'b1)
            act_cnt++;
         if (p == 0)
            lk0 = tim.locked;
      end
   endtask

   task automatic good_line(output int act_cnt, output logic lk0);
      drive_line(528, 400, 410, 484, act_cnt, lk0);
   endtask

   task automatic check_published(input string tag);
      check({tag, "_line_len"},   32'(tim.line_len),   528);
      check({tag, "_act_w"},      32'(tim.act_w),      400);
      check({tag, "_sync_start"}, 32'(tim.sync_start), 410);
      check({tag, "_sync_end"},   32'(tim.sync_end),   484);
   endtask

   initial begin
      rst = 1'b1;
      tim.blank_in = 1'b1;
      tim.sync_in  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_x_pos",      32'(tim.x_pos),      0);
      check("rst_locked",     32'(tim.locked),     0);
      check("rst_active",     32'(tim.active),     0);
      check("rst_timing_err", 32'(tim.timing_err), 0);
      check("rst_line_len",   32'(tim.line_len),   0);
      check("rst_sync_end",   32'(tim.sync_end),   0);
      rst = 1'b0;

      // Initial acquisition: lock appears on the blank fall ending line 4.
      for (int i = 0; i < 4; i++) begin
         good_line(a, l);
         check("acq_active_cnt", a, 0);
         check("acq_lk0", 32'(l), 0);
      end
      check("acq_locked_before", 32'(tim.locked), 0);
      good_line(a, l);
      check("acq_lk0_line5", 32'(l), 1);
      check("acq_active_cnt_locked", a, 400);
      check("acq_x_pos_end", 32'(tim.x_pos), 527);
      check("acq_active_blanked", 32'(tim.active), 0);
      check_published("acq");
      check("acq_err_count", err_hi, 0);

      // Short line while locked.
      drive_line(527, 400, 410, 484, a, l);
      check("short_still_locked", 32'(l), 1);
      check("short_active_cnt", a, 400);
      good_line(a, l);
      check("short_lk0_drop", 32'(l), 0);
      check("short_active_unlocked", a, 0);
      check("short_err_count", err_hi, 1);
      check_published("short_hold");
      for (int i = 0; i < 3; i++) begin
         good_line(a, l);
         check("short_relock_lk0", 32'(l), 0);
      end
      good_line(a, l);
      check("short_relocked", 32'(l), 1);
      check("short_relock_active", a, 400);
      check_published("short_relock");
      check("short_err_single", err_hi, 1);

      // Line without any sync pulse while locked.
      drive_line(528, 400, 1000, 1000, a, l);
      check("nosync_still_locked", 32'(l), 1);
      good_line(a, l);
      check("nosync_lk0_drop", 32'(l), 0);
      check("nosync_err_count", err_hi, 2);
      check_published("nosync_hold");
      for (int i = 0; i < 3; i++)
         good_line(a, l);
      good_line(a, l);
      check("nosync_relocked", 32'(l), 1);

      // Blank held low: counter saturates, lock dropped one cycle after reaching 1023.
      tim.blank_in = 1'b0;
      tim.sync_in  = 1'b0;
      lk_a = 1'b0;
      lk_b = 1'b1;
      eb   = 1'b0;
      xa   = '0;
      for (int i = 0; i < 1100; i++) begin
         @(posedge clk);
         #1;
         if (i == 1023) begin
            lk_a = tim.locked;
            xa   = tim.x_pos;
         end
         if (i == 1024) begin
            lk_b = tim.locked;
            eb   = tim.timing_err;
         end
      end
      check("to_locked_at_1023", 32'(lk_a), 1);
      check("to_x_pos_at_1023", 32'(xa), 1023);
      check("to_locked_after", 32'(lk_b), 0);
      check("to_err_pulse", 32'(eb), 1);
      check("to_x_pos_sat", 32'(tim.x_pos), 1023);
      check("to_locked_end", 32'(tim.locked), 0);
      check("to_err_count", err_hi, 3);
      check_published("to_hold");

      // Recover from SEARCH: first line has no blank fall, then 4 lines to lock.
      for (int i = 0; i < 5; i++) begin
         good_line(a, l);
         check("rec_active_cnt", a, 0);
      end
      drive_line(200, 400, 410, 484, a, l);
      check("rec_relocked", 32'(l), 1);
      check("rec_active_partial", a, 200);

      // Asynchronous reset mid-line while locked.
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_locked",     32'(tim.locked),     0);
      check("mid_rst_active",     32'(tim.active),     0);
      check("mid_rst_x_pos",      32'(tim.x_pos),      0);
      check("mid_rst_line_len",   32'(tim.line_len),   0);
      check("mid_rst_act_w",      32'(tim.act_w),      0);
      check("mid_rst_sync_start", 32'(tim.sync_start), 0);
      check("mid_rst_timing_err", 32'(tim.timing_err), 0);
      tim.blank_in = 1'b1;
      tim.sync_in  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         good_line(a, l);
         check("post_rst_lk0", 32'(l), 0);
      end
      good_line(a, l);
      check("post_rst_relocked", 32'(l), 1);
      check("post_rst_active", a, 400);
      check_published("post_rst");
      check("post_rst_err_count", err_hi, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/line_timing_decoder.md
LINE_TIMING_DECODER -- requirements
Module: line_timing_decoder

Interface
REQ-001 Parameter: LOCK_LINES, default 4, number of consecutive identical lines required to declare lock (range 2..15).
REQ-002 Port: clk  input  1  pixel clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: blank_in  input  1  incoming blanking, high = blanked; same clock domain as clk.
REQ-005 Port: sync_in  input  1  incoming horizontal sync, high = asserted.
REQ-006 Port: x_pos  output  10  recovered pixel position within the line.
REQ-007 Port: active  output  1  high when locked and the current pixel is unblanked.
REQ-008 Port: locked  output  1  line timing stable and published.
REQ-009 Port: line_len, act_w, sync_start, sync_end  output  10 each  published timing: total pixels, active pixels, sync rise position, sync fall position.
REQ-010 Port: timing_err  output  1  one-cycle pulse on lost lock or timeout.

Function
REQ-011 blank_in and sync_in SHALL be registered once (blank_q, sync_q); all outputs are aligned to blank_q/sync_q, 1-cycle latency from the inputs.
REQ-012 Blank fall = blank_q 1 and blank_in 0 at a clock edge; rise, sync rise and sync fall are defined the same way.
REQ-013 On blank fall, x_pos SHALL load 0; otherwise it SHALL increment by 1 per clock.
REQ-014 A working set SHALL capture, at the event edge, x_pos+1: act_w at blank rise, sync_start at sync rise, sync_end at sync fall, line_len at blank fall.
REQ-015 A line SHALL be valid only if it contains exactly one blank rise, one sync rise and one sync fall, ordered act_w <= sync_start < sync_end <= line_len; any other line is a mismatch.
REQ-016 Sync edges coincident with blank fall SHALL be attributed to the new line at position 0, which makes that line invalid.
REQ-017 States: SEARCH, MEASURE, TRACK, LOCKED.
REQ-018 SEARCH: wait for blank fall -> MEASURE; match count cleared.
REQ-019 MEASURE: at next blank fall, store the working set as the reference -> TRACK with match count 0; an invalid line -> stay in MEASURE.
REQ-020 TRACK: at each blank fall, valid line equal to the reference increments the match count; reaching LOCK_LINES-1 -> LOCKED; a mismatch loads the new set as the reference and clears the count.
REQ-021 LOCKED: locked = 1; published outputs equal the reference and SHALL not change while locked; a mismatch -> timing_err pulse, locked = 0, state MEASURE, with the mismatching line discarded.
REQ-022 Timeout: if x_pos reaches 1023 without blank fall, in any state except SEARCH -> SEARCH next cycle; x_pos holds at 1023; timing_err pulses only when leaving LOCKED.
REQ-023 active SHALL equal locked AND NOT blank_q.
REQ-024 Published outputs SHALL update only on entry to LOCKED and hold their values after lock loss until the next lock.

Reset
REQ-025 While rst is high: state SEARCH, x_pos 0, blank_q 1, sync_q 0, locked 0, active 0, timing_err 0, published outputs 0, match count 0.
REQ-026 Deassertion of rst SHALL take effect on the next clock edge; rst asserted mid-line aborts all measurement immediately.

Verification
REQ-027 Drive the 528-cycle line (blank high for positions 400..527, sync high for 410..483) repeatedly -> locked rises at the end of line 4 after the first blank fall; line_len 528, act_w 400, sync_start 410, sync_end 484.
REQ-028 While locked, shorten one line to 527 -> timing_err single pulse, locked 0; after 4 more good lines, locked rises again with the same values.
REQ-029 While locked, suppress one sync pulse -> mismatch, timing_err pulse, published values held.
REQ-030 Hold blank_in low for 1100 cycles -> x_pos saturates at 1023, state SEARCH, timing_err pulses if previously locked.
REQ-031 Assert rst mid-line while locked -> all outputs 0 asynchronously; lock reacquired after 4 good lines post-release.
REQ-032 Check active equals NOT blank delayed by 1 cycle while locked, and 0 while unlocked.
